// File: rtl/ramarb_pkg.sv
// ramarb_pkg
//   Shared definitions for the RAM arbiter slice.
//   state_t    : top-level sequencer states (zero-fill sweep, then arbitration)
//   ptr_width  : bit width needed to hold a requester index 0..n-1
package ramarb_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // A single requester still needs a one-bit pointer, so clamp at 1.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ramarb_rrpick.sv
// ramarb_rrpick
//   Combinational round-robin picker. Searches valid[] starting at ptr and
//   wrapping modulo N, and returns the first requester found.
// Ports
//   valid  in   N    request valid per requester
//   ptr    in   PW   index where the search starts (highest priority)
//   grant  out  N    one-hot grant, all zero when nothing is valid
//   idx    out  PW   binary index of the granted requester (0 when none)
//   any    out  1    at least one requester is valid
module ramarb_rrpick
    import ramarb_pkg::*;
#(
    parameter int N  = 4,
    parameter int PW = ptr_width(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx,
    output logic          any
);

    // Walk the N candidates in priority order; the wrap is an explicit
    // subtraction so N need not be a power of two.
    always_comb begin
        int cand;
        cand  = 0;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any && valid[cand]) begin
                any         = 1'b1;
                idx         = PW'(cand);
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ramarb.sv
// ramarb
//   Round-robin arbiter and init sequencer for a single-port RAM with
//   synchronous write and combinational read. After reset it optionally
//   sweeps the whole RAM to zero, then grants one request per cycle and
//   returns read data registered one cycle after the grant.
// Ports
//   clk        in   1     clock, all state on posedge
//   rst        in   1     asynchronous reset, active-high
//   req_valid  in   N     request valid per requester
//   req_we     in   N     1=write, 0=read, per requester
//   req_addr   in   N*AW  packed addresses, requester i at [i*AW +: AW]
//   req_din    in   N*DW  packed write data, requester i at [i*DW +: DW]
//   req_ready  out  N     one-hot grant (combinational from req_valid)
//   rsp_valid  out  N     one-hot read-response pulse
//   rsp_data   out  DW    registered read data, shared by all requesters
//   init_done  out  1     high once the zero-fill sweep has completed
//   ram_we     out  1     RAM write enable
//   ram_addr   out  AW    RAM address
//   ram_din    out  DW    RAM write data
//   ram_dout   in   DW    RAM combinational read data
module ramarb
    import ramarb_pkg::*;
#(
    parameter int N    = 4,
    parameter int DW   = 16,
    parameter int AW   = 10,
    parameter int INIT = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    input  logic [N-1:0]    req_we,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_din,
    output logic [N-1:0]    req_ready,
    output logic [N-1:0]    rsp_valid,
    output logic [DW-1:0]   rsp_data,
    output logic            init_done,
    output logic            ram_we,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_din,
    input  logic [DW-1:0]   ram_dout
);

    localparam int            PW       = ptr_width(N);
    localparam logic [PW-1:0] PTR_LAST = PW'(N - 1);
    localparam logic [AW-1:0] CNT_LAST = '1;

    state_t        state;
    state_t        next_state;
    logic [AW-1:0] init_cnt;
    logic [PW-1:0] ptr;
    logic [N-1:0]  pick_grant;
    logic [PW-1:0] pick_idx;
    logic          pick_any;
    logic          read_grant;

    ramarb_rrpick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // State register; with INIT=0 the sweep is skipped entirely.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= (INIT != 0) ? ST_INIT : ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next state and the RAM port mux. During the sweep the counter owns
    // the port; in RUN the granted requester drives it in the same cycle.
    always_comb begin
        next_state = state;
        req_ready  = '0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_din    = '0;
        read_grant = 1'b0;
        case (state)
            ST_INIT: begin
                ram_we   = 1'b1;
                ram_addr = init_cnt;
                if (init_cnt == CNT_LAST) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (pick_any) begin
                    req_ready  = pick_grant;
                    ram_we     = req_we[pick_idx];
                    ram_addr   = req_addr[pick_idx*AW +: AW];
                    ram_din    = req_din[pick_idx*DW +: DW];
                    read_grant = !req_we[pick_idx];
                end
            end
            default: begin
                next_state = ST_INIT;
            end
        endcase
    end

    // Sweep counter; init_done rises on the edge that writes the last word
    // and then stays high until the next reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_cnt  <= '0;
            init_done <= (INIT == 0);
        end else if (state == ST_INIT) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == CNT_LAST) begin
                init_done <= 1'b1;
            end
        end
    end

    // Round-robin pointer moves just past the winner, so the winner has the
    // lowest priority next time. Idle cycles leave it where it is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (state == ST_RUN && pick_any) begin
            ptr <= (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
        end
    end

    // Read data is captured from the combinational RAM output at the grant
    // edge; rsp_data is left alone on writes and idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= read_grant ? pick_grant : '0;
            if (read_grant) begin
                rsp_data <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_ramarb.sv
// tb_ramarb
//   Self-checking bench for ramarb with N=4, DW=16, AW=4. Two instances run
//   side by side: d1 (INIT=1, zero-fill) and d0 (INIT=0). Each has its own
//   RAM model and a reference memory written only by the bench. Expected
//   read responses go into a queue when the read is granted and are popped
//   by a monitor on the following cycle.
module tb_ramarb;

    typedef struct packed {
        logic [3:0]  who;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        mem_load = 1'b1;

    logic        d1_rst;
    logic [3:0]  d1_req_valid, d1_req_we, d1_req_ready, d1_rsp_valid;
    logic [15:0] d1_req_addr;
    logic [63:0] d1_req_din;
    logic [15:0] d1_rsp_data, d1_ram_din, d1_ram_dout;
    logic        d1_init_done, d1_ram_we;
    logic [3:0]  d1_ram_addr;

    logic        d0_rst;
    logic [3:0]  d0_req_valid, d0_req_we, d0_req_ready, d0_rsp_valid;
    logic [15:0] d0_req_addr;
    logic [63:0] d0_req_din;
    logic [15:0] d0_rsp_data, d0_ram_din, d0_ram_dout;
    logic        d0_init_done, d0_ram_we;
    logic [3:0]  d0_ram_addr;

    logic [15:0] mem1 [16];
    logic [15:0] mem0 [16];
    logic [15:0] ref1 [16];
    logic [15:0] ref0 [16];

    exp_t sb1 [$];
    exp_t sb0 [$];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    ramarb #(.N(4), .DW(16), .AW(4), .INIT(1)) dut1 (
        .clk       (clk),
        .rst       (d1_rst),
        .req_valid (d1_req_valid),
        .req_we    (d1_req_we),
        .req_addr  (d1_req_addr),
        .req_din   (d1_req_din),
        .req_ready (d1_req_ready),
        .rsp_valid (d1_rsp_valid),
        .rsp_data  (d1_rsp_data),
        .init_done (d1_init_done),
        .ram_we    (d1_ram_we),
        .ram_addr  (d1_ram_addr),
        .ram_din   (d1_ram_din),
        .ram_dout  (d1_ram_dout)
    );

    ramarb #(.N(4), .DW(16), .AW(4), .INIT(0)) dut0 (
        .clk       (clk),
        .rst       (d0_rst),
        .req_valid (d0_req_valid),
        .req_we    (d0_req_we),
        .req_addr  (d0_req_addr),
        .req_din   (d0_req_din),
        .req_ready (d0_req_ready),
        .rsp_valid (d0_rsp_valid),
        .rsp_data  (d0_rsp_data),
        .init_done (d0_init_done),
        .ram_we    (d0_ram_we),
        .ram_addr  (d0_ram_addr),
        .ram_din   (d0_ram_din),
        .ram_dout  (d0_ram_dout)
    );

    // RAM models: sync write, async read. The first edge preloads nonzero
    // contents so that the zero-fill sweep is visible.
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) begin
                mem1[i] <= 16'(32'hA5A0 + i);
                mem0[i] <= 16'(32'h1000 + i);
            end
        end else begin
            if (d1_ram_we) mem1[d1_ram_addr] <= d1_ram_din;
            if (d0_ram_we) mem0[d0_ram_addr] <= d0_ram_din;
        end
    end

    assign d1_ram_dout = mem1[d1_ram_addr];
    assign d0_ram_dout = mem0[d0_ram_addr];

    // Response monitor: any queued expectation must appear exactly one
    // cycle after its grant; otherwise rsp_valid must be idle.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (sb1.size() > 0) begin
            e = sb1.pop_front();
            if (d1_rsp_valid !== e.who || d1_rsp_data !== e.data) begin
                fails++;
                $display("[TB] FAIL d1_rsp: valid=%b data=%h expected valid=%b data=%h", d1_rsp_valid, d1_rsp_data, e.who, e.data);
            end
        end else if (d1_rsp_valid !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL d1_rsp_idle: valid=%b expected 0000", d1_rsp_valid);
        end
        checks++;
        if (sb0.size() > 0) begin
            e = sb0.pop_front();
            if (d0_rsp_valid !== e.who || d0_rsp_data !== e.data) begin
                fails++;
                $display("[TB] FAIL d0_rsp: valid=%b data=%h expected valid=%b data=%h", d0_rsp_valid, d0_rsp_data, e.who, e.data);
            end
        end else if (d0_rsp_valid !== 4'b0000) begin
            fails++;
            $display("[TB] FAIL d0_rsp_idle: valid=%b expected 0000", d0_rsp_valid);
        end
    end

    task automatic clear_d1();
        d1_req_valid = '0;
        d1_req_we    = '0;
        d1_req_addr  = '0;
        d1_req_din   = '0;
    endtask

    task automatic clear_d0();
        d0_req_valid = '0;
        d0_req_we    = '0;
        d0_req_addr  = '0;
        d0_req_din   = '0;
    endtask

    // Reset values, then the 16-cycle zero-fill sweep with requests pending.
    task automatic test_reset();
        d1_rst = 1'b1;
        d0_rst = 1'b1;
        clear_d1();
        clear_d0();
        #1;
        checks++;
        if (d1_init_done !== 1'b0 || d1_ram_we !== 1'b1 || d1_ram_addr !== 4'd0 || d1_ram_din !== 16'h0) begin
            fails++;
            $display("[TB] FAIL reset_d1: init_done=%b we=%b addr=%0d din=%h expected 0 1 0 0000", d1_init_done, d1_ram_we, d1_ram_addr, d1_ram_din);
        end
        checks++;
        if (d1_rsp_valid !== 4'b0 || d1_rsp_data !== 16'h0) begin
            fails++;
            $display("[TB] FAIL reset_rsp: valid=%b data=%h expected 0000 0000", d1_rsp_valid, d1_rsp_data);
        end
        checks++;
        if (d0_init_done !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_d0_init_done: got %b expected 1", d0_init_done);
        end
        @(negedge clk);
        mem_load = 1'b0;
        d1_rst = 1'b0;
        d0_rst = 1'b0;
        d1_req_valid = 4'hF;
        for (int c = 0; c < 16; c++) begin
            #1;
            checks++;
            if (d1_ram_we !== 1'b1 || d1_ram_addr !== 4'(c) || d1_ram_din !== 16'h0 || d1_req_ready !== 4'b0 || d1_init_done !== 1'b0) begin
                fails++;
                $display("[TB] FAIL sweep c=%0d: we=%b addr=%0d din=%h ready=%b done=%b expected 1 %0d 0000 0000 0", c, d1_ram_we, d1_ram_addr, d1_ram_din, d1_req_ready, d1_init_done, c);
            end
            ref1[c] = 16'h0;
            @(negedge clk);
        end
        clear_d1();
        #1;
        checks++;
        if (d1_init_done !== 1'b1 || d1_ram_we !== 1'b0 || d1_ram_addr !== 4'd0 || d1_req_ready !== 4'b0) begin
            fails++;
            $display("[TB] FAIL sweep_end: done=%b we=%b addr=%0d ready=%b expected 1 0 0 0000", d1_init_done, d1_ram_we, d1_ram_addr, d1_req_ready);
        end
        @(negedge clk);
    endtask

    // Requester 3 reads every address; all must be zero after the sweep.
    // Each grant to 3 wraps the pointer back to 0.
    task automatic test_zero_readback();
        for (int a = 0; a < 16; a++) begin
            clear_d1();
            d1_req_valid = 4'b1000;
            d1_req_addr[12 +: 4] = 4'(a);
            #1;
            checks++;
            if (d1_req_ready !== 4'b1000 || d1_ram_addr !== 4'(a) || d1_ram_we !== 1'b0) begin
                fails++;
                $display("[TB] FAIL readback a=%0d: ready=%b addr=%0d we=%b expected 1000 %0d 0", a, d1_req_ready, d1_ram_addr, d1_ram_we, a);
            end
            sb1.push_back('{who: 4'b1000, data: ref1[a]});
            @(negedge clk);
        end
        clear_d1();
        @(negedge clk);
    endtask

    // All four reading continuously: grants rotate 0,1,2,3,0.
    task automatic test_round_robin();
        int   gseq [5];
        logic [3:0] exp_g;
        gseq = '{0, 1, 2, 3, 0};
        clear_d1();
        d1_req_valid = 4'hF;
        for (int i = 0; i < 4; i++) d1_req_addr[i*4 +: 4] = 4'(i + 2);
        for (int c = 0; c < 5; c++) begin
            exp_g = 4'b0001 << gseq[c];
            #1;
            checks++;
            if (d1_req_ready !== exp_g || d1_ram_addr !== 4'(gseq[c] + 2)) begin
                fails++;
                $display("[TB] FAIL rr c=%0d: ready=%b addr=%0d expected %b %0d", c, d1_req_ready, d1_ram_addr, exp_g, gseq[c] + 2);
            end
            sb1.push_back('{who: exp_g, data: ref1[gseq[c] + 2]});
            @(negedge clk);
        end
        clear_d1();
        @(negedge clk);
    endtask

    // Requester 1 writes 0xBEEF to address 5, requester 3 reads it back
    // on the very next cycle.
    task automatic test_raw();
        clear_d1();
        d1_req_valid = 4'b0010;
        d1_req_we    = 4'b0010;
        d1_req_addr[4 +: 4] = 4'd5;
        d1_req_din[16 +: 16] = 16'hBEEF;
        #1;
        checks++;
        if (d1_req_ready !== 4'b0010 || d1_ram_we !== 1'b1 || d1_ram_addr !== 4'd5 || d1_ram_din !== 16'hBEEF) begin
            fails++;
            $display("[TB] FAIL raw_write: ready=%b we=%b addr=%0d din=%h expected 0010 1 5 beef", d1_req_ready, d1_ram_we, d1_ram_addr, d1_ram_din);
        end
        ref1[5] = 16'hBEEF;
        @(negedge clk);
        clear_d1();
        d1_req_valid = 4'b1000;
        d1_req_addr[12 +: 4] = 4'd5;
        #1;
        checks++;
        if (d1_req_ready !== 4'b1000 || d1_ram_we !== 1'b0 || d1_ram_addr !== 4'd5) begin
            fails++;
            $display("[TB] FAIL raw_read: ready=%b we=%b addr=%0d expected 1000 0 5", d1_req_ready, d1_ram_we, d1_ram_addr);
        end
        sb1.push_back('{who: 4'b1000, data: ref1[5]});
        @(negedge clk);
        clear_d1();
        @(negedge clk);
    endtask

    // Requester 2 alone for three writes leaves the pointer at 3, so with
    // 0 and 3 both requesting, 3 goes first and then 0.
    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            clear_d1();
            d1_req_valid = 4'b0100;
            d1_req_we    = 4'b0100;
            d1_req_addr[8 +: 4]  = 4'(k + 1);
            d1_req_din[32 +: 16] = 16'(32'h2000 + k);
            #1;
            checks++;
            if (d1_req_ready !== 4'b0100 || d1_ram_we !== 1'b1 || d1_ram_addr !== 4'(k + 1)) begin
                fails++;
                $display("[TB] FAIL solo k=%0d: ready=%b we=%b addr=%0d expected 0100 1 %0d", k, d1_req_ready, d1_ram_we, d1_ram_addr, k + 1);
            end
            ref1[k + 1] = 16'(32'h2000 + k);
            @(negedge clk);
        end
        clear_d1();
        d1_req_valid = 4'b1001;
        d1_req_addr[0 +: 4]  = 4'd3;
        d1_req_addr[12 +: 4] = 4'd2;
        #1;
        checks++;
        if (d1_req_ready !== 4'b1000 || d1_ram_addr !== 4'd2) begin
            fails++;
            $display("[TB] FAIL pair_first: ready=%b addr=%0d expected 1000 2", d1_req_ready, d1_ram_addr);
        end
        sb1.push_back('{who: 4'b1000, data: ref1[2]});
        @(negedge clk);
        #1;
        checks++;
        if (d1_req_ready !== 4'b0001 || d1_ram_addr !== 4'd3) begin
            fails++;
            $display("[TB] FAIL pair_second: ready=%b addr=%0d expected 0001 3", d1_req_ready, d1_ram_addr);
        end
        sb1.push_back('{who: 4'b0001, data: ref1[3]});
        @(negedge clk);
        clear_d1();
        @(negedge clk);
        #1;
        checks++;
        if (d1_rsp_data !== ref1[3] || d1_rsp_valid !== 4'b0) begin
            fails++;
            $display("[TB] FAIL rsp_hold: data=%h valid=%b expected %h 0000", d1_rsp_data, d1_rsp_valid, ref1[3]);
        end
        @(negedge clk);
    endtask

    // Reset at sweep counter 7 restarts the sweep from address 0.
    task automatic test_reset_midsweep();
        clear_d1();
        d1_rst = 1'b1;
        d1_req_valid = 4'hF;
        @(negedge clk);
        d1_rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            #1;
            checks++;
            if (d1_ram_addr !== 4'(c) || d1_req_ready !== 4'b0) begin
                fails++;
                $display("[TB] FAIL presweep c=%0d: addr=%0d ready=%b expected %0d 0000", c, d1_ram_addr, d1_req_ready, c);
            end
            @(negedge clk);
        end
        #1;
        d1_rst = 1'b1;
        #1;
        checks++;
        if (d1_ram_addr !== 4'd0 || d1_ram_we !== 1'b1 || d1_init_done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midsweep_rst: addr=%0d we=%b done=%b expected 0 1 0", d1_ram_addr, d1_ram_we, d1_init_done);
        end
        @(negedge clk);
        d1_rst = 1'b0;
        for (int c = 0; c < 16; c++) begin
            #1;
            checks++;
            if (d1_ram_we !== 1'b1 || d1_ram_addr !== 4'(c) || d1_init_done !== 1'b0 || d1_req_ready !== 4'b0) begin
                fails++;
                $display("[TB] FAIL resweep c=%0d: we=%b addr=%0d done=%b ready=%b expected 1 %0d 0 0000", c, d1_ram_we, d1_ram_addr, d1_init_done, d1_req_ready, c);
            end
            ref1[c] = 16'h0;
            @(negedge clk);
        end
        clear_d1();
        d1_req_valid = 4'b0001;
        d1_req_addr[0 +: 4] = 4'd5;
        #1;
        checks++;
        if (d1_init_done !== 1'b1 || d1_req_ready !== 4'b0001) begin
            fails++;
            $display("[TB] FAIL resweep_run: done=%b ready=%b expected 1 0001", d1_init_done, d1_req_ready);
        end
        sb1.push_back('{who: 4'b0001, data: ref1[5]});
        @(negedge clk);
        clear_d1();
        @(negedge clk);
    endtask

    // INIT=0 instance: usable straight out of reset, writes never respond.
    task automatic test_init0();
        for (int i = 0; i < 16; i++) ref0[i] = 16'(32'h1000 + i);
        clear_d0();
        d0_rst = 1'b1;
        d0_req_valid = 4'b0001;
        d0_req_addr[0 +: 4] = 4'd2;
        #1;
        checks++;
        if (d0_init_done !== 1'b1 || d0_ram_we !== 1'b0) begin
            fails++;
            $display("[TB] FAIL init0_reset: done=%b we=%b expected 1 0", d0_init_done, d0_ram_we);
        end
        @(negedge clk);
        d0_rst = 1'b0;
        #1;
        checks++;
        if (d0_req_ready !== 4'b0001 || d0_ram_addr !== 4'd2 || d0_init_done !== 1'b1) begin
            fails++;
            $display("[TB] FAIL init0_first: ready=%b addr=%0d done=%b expected 0001 2 1", d0_req_ready, d0_ram_addr, d0_init_done);
        end
        sb0.push_back('{who: 4'b0001, data: ref0[2]});
        @(negedge clk);
        clear_d0();
        d0_req_valid = 4'b0110;
        d0_req_we    = 4'b0110;
        d0_req_addr[4 +: 4]  = 4'd2;
        d0_req_din[16 +: 16] = 16'h1234;
        d0_req_addr[8 +: 4]  = 4'd3;
        d0_req_din[32 +: 16] = 16'h5678;
        #1;
        checks++;
        if (d0_req_ready !== 4'b0010 || d0_ram_we !== 1'b1 || d0_ram_addr !== 4'd2 || d0_ram_din !== 16'h1234) begin
            fails++;
            $display("[TB] FAIL init0_w1: ready=%b we=%b addr=%0d din=%h expected 0010 1 2 1234", d0_req_ready, d0_ram_we, d0_ram_addr, d0_ram_din);
        end
        ref0[2] = 16'h1234;
        @(negedge clk);
        d0_req_valid = 4'b0100;
        #1;
        checks++;
        if (d0_req_ready !== 4'b0100 || d0_ram_din !== 16'h5678 || d0_rsp_data !== 16'h1002) begin
            fails++;
            $display("[TB] FAIL init0_w2: ready=%b din=%h rsp_data=%h expected 0100 5678 1002", d0_req_ready, d0_ram_din, d0_rsp_data);
        end
        ref0[3] = 16'h5678;
        @(negedge clk);
        clear_d0();
        d0_req_valid = 4'b1000;
        d0_req_addr[12 +: 4] = 4'd2;
        #1;
        checks++;
        if (d0_req_ready !== 4'b1000 || d0_ram_we !== 1'b0) begin
            fails++;
            $display("[TB] FAIL init0_read: ready=%b we=%b expected 1000 0", d0_req_ready, d0_ram_we);
        end
        sb0.push_back('{who: 4'b1000, data: ref0[2]});
        @(negedge clk);
        clear_d0();
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] ramarb bench start");
        test_reset();
        test_zero_readback();
        test_round_robin();
        test_raw();
        test_back_to_back();
        test_reset_midsweep();
        test_init0();
        @(negedge clk);
        checks++;
        if (sb1.size() != 0 || sb0.size() != 0) begin
            fails++;
            $display("[TB] FAIL scoreboard_drain: pending d1=%0d d0=%0d expected 0 0", sb1.size(), sb0.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
